issue_select: RTL and testbench

ISSUE_SELECT -- requirements
Module: issue_select

---
 rtl/backend_types.sv | 17 +
 rtl/issue_select_pkg.sv | 20 ++
 rtl/issue_select_age_matrix.sv | 60 ++++++
 rtl/issue_select.sv | 82 ++++++++
 tb/tb_issue_select.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/backend_types.sv
// Shared backend types: reservation-station entry layout, branch tag width
// and integer issue queue depth.
package backend_types;

  localparam int INT_ISSUE_DEPTH = 4;
  localparam int BR_TAG_WIDTH    = 2;
  localparam int MAX_BR          = 1 << BR_TAG_WIDTH;

  typedef struct packed {
    logic [7:0]        opcode;
    logic [5:0]        pdst;
    logic [5:0]        prs1;
    logic [5:0]        prs2;
    logic [MAX_BR-1:0] branch_mask;
  } res_entry_t;

endpackage

// File: rtl/issue_select_pkg.sv
// Helpers for issue_select, built only on backend_types.
package issue_select_pkg;
  import backend_types::*;

  // A resolved-clean branch no longer guards the micro-op.
  function automatic res_entry_t clear_branch(input res_entry_t e,
                                              input logic en,
                                              input logic [BR_TAG_WIDTH-1:0] tag);
    res_entry_t r;
    r = e;
    if (en) r.branch_mask[tag] = 1'b0;
    return r;
  endfunction

  function automatic logic branch_hit(input res_entry_t e,
                                      input logic [BR_TAG_WIDTH-1:0] tag);
    return e.branch_mask[tag];
  endfunction

endpackage

// File: rtl/issue_select_age_matrix.sv
// age_matrix: oldest-first grant among requesting RS entries.
// Define ISSUE_SELECT_AGE_EN to enable the age matrix; otherwise lowest index wins.
module age_matrix #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic [ADDR_WIDTH-1:0] alloc_idx,
  input  logic [DEPTH-1:0]      req,
  output logic [DEPTH-1:0]      grant
);

  logic [DEPTH-1:0] cand;
  logic             found;

`ifdef ISSUE_SELECT_AGE_EN
  logic [DEPTH-1:0] age [DEPTH];

  // A new entry is younger than every resident entry; stale rows of freed
  // entries are masked by req, so they are never cleaned up.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) age[r] <= '0;
    end else if (alloc_valid) begin
      for (int r = 0; r < DEPTH; r++) begin
        if (ADDR_WIDTH'(r) == alloc_idx) age[r] <= '0;
        else                             age[r][alloc_idx] <= 1'b1;
      end
    end
  end

  always_comb begin
    cand = req;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (req[j] && age[j][i]) cand[i] = 1'b0;
      end
    end
  end
`else
  logic unused_age_inputs;
  assign unused_age_inputs = ^{clk, rst, alloc_valid, alloc_idx};
  assign cand = req;
`endif

  // Lowest-index pick keeps the grant one-hot even if ages tie.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cand[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_select.sv
// issue_select: picks one ready RS entry per cycle into a single issue register.
// ISSUE_SELECT_AGE_EN selects oldest-first arbitration inside age_matrix.
module issue_select
  import backend_types::*;
  import issue_select_pkg::*;
#(
  parameter int DEPTH      = INT_ISSUE_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_valid,
  input  logic [ADDR_WIDTH-1:0]   alloc_idx,
  input  logic [DEPTH-1:0]        req,
  input  res_entry_t              rs_rdata,
  output logic                    ren,
  output logic [ADDR_WIDTH-1:0]   raddr,
  output logic                    iss_valid,
  output res_entry_t              iss_data,
  input  logic                    iss_ready,
  input  logic                    br_broadcast,
  input  logic                    br_clean,
  input  logic                    br_kill,
  input  logic [BR_TAG_WIDTH-1:0] br_tag
);

  logic [DEPTH-1:0]      grant;
  logic [ADDR_WIDTH-1:0] win_idx;
  logic                  has_winner;
  logic                  can_accept;
  logic                  do_clean;
  logic                  kill_cap;
  logic                  kill_held;
  res_entry_t            cap_data;
  res_entry_t            held_data;

  age_matrix #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_age_matrix (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_idx   (alloc_idx),
    .req         (req),
    .grant       (grant)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) win_idx = win_idx | ADDR_WIDTH'(i);
    end
  end

  assign has_winner = |grant;
  assign can_accept = !iss_valid || iss_ready;
  assign ren        = !rst && has_winner && can_accept;
  assign raddr      = ren ? win_idx : '0;

  // Kill never blocks the read: the RS slot is freed and the kill only
  // suppresses the valid bit of whatever lands in the issue register.
  assign do_clean  = br_broadcast && br_clean;
  assign cap_data  = clear_branch(rs_rdata, do_clean, br_tag);
  assign held_data = clear_branch(iss_data, do_clean, br_tag);
  assign kill_cap  = br_broadcast && br_kill && branch_hit(rs_rdata, br_tag);
  assign kill_held = br_broadcast && br_kill && branch_hit(iss_data, br_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_data  <= '0;
    end else if (ren) begin
      iss_valid <= !kill_cap;
      iss_data  <= cap_data;
    end else begin
      iss_valid <= iss_valid && !iss_ready && !kill_held;
      iss_data  <= held_data;
    end
  end

endmodule

// File: tb/tb_issue_select.sv
// Self-checking bench for issue_select; expectations follow ISSUE_SELECT_AGE_EN.
module tb_issue_select;
  import backend_types::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0] req;
    logic       exp_ren;
    logic [1:0] exp_raddr;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_valid;
  logic [1:0]        alloc_idx;
  logic [DEPTH-1:0]  req;
  res_entry_t        rs_rdata;
  logic              ren;
  logic [1:0]        raddr;
  logic              iss_valid;
  res_entry_t        iss_data;
  logic              iss_ready;
  logic              br_broadcast;
  logic              br_clean;
  logic              br_kill;
  logic [1:0]        br_tag;

  res_entry_t rs_mem [DEPTH];
  res_entry_t exp_q [$];
  res_entry_t exp_e;
  int         n_vec = 0;
  int         n_err = 0;
  logic       auto_free = 1'b0;
  logic       freed_v;
  logic [1:0] freed_i;
  logic [1:0] order [3];
  vec_t       vecs [8];

  always #5 clk = ~clk;

  // RS read port model: combinational read at the selected address.
  always_comb rs_rdata = rs_mem[raddr];

  issue_select #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_idx    (alloc_idx),
    .req          (req),
    .rs_rdata     (rs_rdata),
    .ren          (ren),
    .raddr        (raddr),
    .iss_valid    (iss_valid),
    .iss_data     (iss_data),
    .iss_ready    (iss_ready),
    .br_broadcast (br_broadcast),
    .br_clean     (br_clean),
    .br_kill      (br_kill),
    .br_tag       (br_tag)
  );

  function automatic res_entry_t mk(input int i, input logic [3:0] m);
    res_entry_t e;
    e.opcode      = 8'(8'hA0 + i);
    e.pdst        = 6'(i + 8);
    e.prs1        = 6'(i + 16);
    e.prs2        = 6'(i + 24);
    e.branch_mask = m;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic rdy,
                               input logic av, input logic [1:0] ai);
    req          = r;
    iss_ready    = rdy;
    alloc_valid  = av;
    alloc_idx    = ai;
    br_broadcast = 1'b0;
    br_clean     = 1'b0;
    br_kill      = 1'b0;
    br_tag       = 2'd0;
  endtask

  task automatic setBranch(input logic clean, input logic kill, input logic [1:0] tag);
    br_broadcast = clean | kill;
    br_clean     = clean;
    br_kill      = kill;
    br_tag       = tag;
  endtask

  // One clock: mid-cycle scoreboard check of accepted micro-ops, then the
  // edge, then the RS model drops any entry that was read.
  task automatic tick();
    @(negedge clk);
    if (!rst && iss_valid && iss_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected_issue", 64'(iss_data), 64'(0));
      end else begin
        exp_e = exp_q.pop_front();
        checkOutput("sb_data", 64'(iss_data), 64'(exp_e));
      end
    end
    freed_v = ren;
    freed_i = raddr;
    @(posedge clk);
    #2;
    if (auto_free && freed_v) req[freed_i] = 1'b0;
  endtask

  task automatic loadRs();
    for (int i = 0; i < DEPTH; i++) rs_mem[i] = mk(i, 4'b0000);
  endtask

  task automatic doReset();
    loadRs();
    rst = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0);
    tick();
    rst = 1'b0;
  endtask

  task automatic issueCheck(input string name, input logic [1:0] idx);
    checkOutput({name, "_ren"}, 64'(ren), 64'(1));
    checkOutput({name, "_raddr"}, 64'(raddr), 64'(idx));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    loadRs();
    rst = 1'b1;
    applyStimulus(4'b1111, 1'b1, 1'b0, 2'd0);
    @(posedge clk);
    #2;
    checkOutput("rst_ren", 64'(ren), 64'(0));
    checkOutput("rst_raddr", 64'(raddr), 64'(0));
    checkOutput("rst_iss_valid", 64'(iss_valid), 64'(0));
    checkOutput("rst_iss_data", 64'(iss_data), 64'(0));
    rst = 1'b0;

    // No allocations yet, so both arbitration modes pick the lowest index.
    vecs[0] = '{4'b0000, 1'b0, 2'd0};
    vecs[1] = '{4'b0001, 1'b1, 2'd0};
    vecs[2] = '{4'b1000, 1'b1, 2'd3};
    vecs[3] = '{4'b0110, 1'b1, 2'd1};
    vecs[4] = '{4'b1100, 1'b1, 2'd2};
    vecs[5] = '{4'b1111, 1'b1, 2'd0};
    vecs[6] = '{4'b1010, 1'b1, 2'd1};
    vecs[7] = '{4'b0000, 1'b0, 2'd0};
    for (int k = 0; k < 8; k++) begin
      applyStimulus(vecs[k].req, 1'b1, 1'b0, 2'd0);
      #1;
      checkOutput($sformatf("vec%0d_ren", k), 64'(ren), 64'(vecs[k].exp_ren));
      checkOutput($sformatf("vec%0d_raddr", k), 64'(raddr), 64'(vecs[k].exp_raddr));
      if (vecs[k].exp_ren) exp_q.push_back(rs_mem[vecs[k].exp_raddr]);
      tick();
      checkOutput($sformatf("vec%0d_iss_valid", k), 64'(iss_valid), 64'(vecs[k].exp_ren));
    end
    applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0);
    tick();
    checkOutput("vec_drain", 64'(exp_q.size()), 64'(0));

    // Allocate 2, 0, 3 then issue back to back.
    doReset();
    applyStimulus(4'b0000, 1'b1, 1'b1, 2'd2); tick();
    applyStimulus(4'b0000, 1'b1, 1'b1, 2'd0); tick();
    applyStimulus(4'b0000, 1'b1, 1'b1, 2'd3); tick();
`ifdef ISSUE_SELECT_AGE_EN
    order[0] = 2'd2; order[1] = 2'd0; order[2] = 2'd3;
`else
    order[0] = 2'd0; order[1] = 2'd2; order[2] = 2'd3;
`endif
    auto_free = 1'b1;
    applyStimulus(4'b1101, 1'b1, 1'b0, 2'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      issueCheck($sformatf("b2b%0d", k), order[k]);
      exp_q.push_back(rs_mem[order[k]]);
      tick();
      checkOutput($sformatf("b2b%0d_iss_valid", k), 64'(iss_valid), 64'(1));
    end
    #1;
    checkOutput("b2b_idle_ren", 64'(ren), 64'(0));
    tick();
    checkOutput("b2b_idle_iss_valid", 64'(iss_valid), 64'(0));
    checkOutput("b2b_drain", 64'(exp_q.size()), 64'(0));
    auto_free = 1'b0;

    // Allocate 3 then 1 with req 1010.
    doReset();
    applyStimulus(4'b0000, 1'b1, 1'b1, 2'd3); tick();
    applyStimulus(4'b0000, 1'b1, 1'b1, 2'd1); tick();
`ifdef ISSUE_SELECT_AGE_EN
    order[0] = 2'd3; order[1] = 2'd1;
`else
    order[0] = 2'd1; order[1] = 2'd3;
`endif
    auto_free = 1'b1;
    applyStimulus(4'b1010, 1'b1, 1'b0, 2'd0);
    for (int k = 0; k < 2; k++) begin
      #1;
      issueCheck($sformatf("alloc31_%0d", k), order[k]);
      exp_q.push_back(rs_mem[order[k]]);
      tick();
    end
    tick();
    checkOutput("alloc31_drain", 64'(exp_q.size()), 64'(0));
    auto_free = 1'b0;

    // Stall: request stays up while the execution unit is busy.
    doReset();
    applyStimulus(4'b0010, 1'b0, 1'b0, 2'd0);
    #1;
    issueCheck("stall_c1", 2'd1);
    exp_q.push_back(rs_mem[1]);
    tick();
    checkOutput("stall_c1_iss_valid", 64'(iss_valid), 64'(1));
    checkOutput("stall_c1_iss_data", 64'(iss_data), 64'(rs_mem[1]));
    for (int c = 2; c <= 3; c++) begin
      #1;
      checkOutput($sformatf("stall_c%0d_ren", c), 64'(ren), 64'(0));
      tick();
      checkOutput($sformatf("stall_c%0d_iss_valid", c), 64'(iss_valid), 64'(1));
      checkOutput($sformatf("stall_c%0d_iss_data", c), 64'(iss_data), 64'(rs_mem[1]));
    end
    applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0);
    tick();
    checkOutput("stall_release_iss_valid", 64'(iss_valid), 64'(0));
    checkOutput("stall_drain", 64'(exp_q.size()), 64'(0));

    // Kill of a held micro-op: other tag first, then the matching tag.
    doReset();
    rs_mem[1] = mk(1, 4'b0010);
    applyStimulus(4'b0010, 1'b0, 1'b0, 2'd0);
    tick();
    checkOutput("kill_setup_iss_valid", 64'(iss_valid), 64'(1));
    applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0);
    setBranch(1'b0, 1'b1, 2'd0);
    tick();
    checkOutput("kill_other_tag_iss_valid", 64'(iss_valid), 64'(1));
    applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0);
    setBranch(1'b0, 1'b1, 2'd1);
    tick();
    checkOutput("kill_held_iss_valid", 64'(iss_valid), 64'(0));

    // Kill of the micro-op being captured: read still happens.
    rs_mem[2] = mk(2, 4'b0100);
    applyStimulus(4'b0100, 1'b1, 1'b0, 2'd0);
    setBranch(1'b0, 1'b1, 2'd2);
    #1;
    issueCheck("kill_cap", 2'd2);
    tick();
    checkOutput("kill_cap_iss_valid", 64'(iss_valid), 64'(0));

    // Clean on capture, then clean on a held micro-op.
    doReset();
    rs_mem[2] = mk(2, 4'b0100);
    rs_mem[3] = mk(3, 4'b1000);
    applyStimulus(4'b0100, 1'b0, 1'b0, 2'd0);
    setBranch(1'b1, 1'b0, 2'd2);
    #1;
    issueCheck("clean_cap", 2'd2);
    exp_e = rs_mem[2];
    exp_e.branch_mask = 4'b0000;
    exp_q.push_back(exp_e);
    tick();
    checkOutput("clean_cap_iss_valid", 64'(iss_valid), 64'(1));
    checkOutput("clean_cap_mask", 64'(iss_data.branch_mask), 64'(4'b0000));
    applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0);
    tick();
    applyStimulus(4'b1000, 1'b0, 1'b0, 2'd0);
    exp_e = rs_mem[3];
    exp_e.branch_mask = 4'b0000;
    exp_q.push_back(exp_e);
    tick();
    checkOutput("clean_held_pre_mask", 64'(iss_data.branch_mask), 64'(4'b1000));
    applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0);
    setBranch(1'b1, 1'b0, 2'd3);
    tick();
    checkOutput("clean_held_iss_valid", 64'(iss_valid), 64'(1));
    checkOutput("clean_held_mask", 64'(iss_data.branch_mask), 64'(4'b0000));
    applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0);
    tick();
    checkOutput("clean_drain", 64'(exp_q.size()), 64'(0));

    // Reset mid-handshake, then allocate 1 then 0.
    doReset();
    applyStimulus(4'b0001, 1'b0, 1'b0, 2'd0);
    tick();
    checkOutput("rstmid_setup_iss_valid", 64'(iss_valid), 64'(1));
    rst = 1'b1;
    applyStimulus(4'b0010, 1'b1, 1'b0, 2'd0);
    #1;
    checkOutput("rstmid_ren", 64'(ren), 64'(0));
    tick();
    checkOutput("rstmid_iss_valid", 64'(iss_valid), 64'(0));
    checkOutput("rstmid_iss_data", 64'(iss_data), 64'(0));
    rst = 1'b0;
    applyStimulus(4'b0000, 1'b1, 1'b1, 2'd1); tick();
    applyStimulus(4'b0000, 1'b1, 1'b1, 2'd0); tick();
`ifdef ISSUE_SELECT_AGE_EN
    order[0] = 2'd1; order[1] = 2'd0;
`else
    order[0] = 2'd0; order[1] = 2'd1;
`endif
    auto_free = 1'b1;
    applyStimulus(4'b0011, 1'b1, 1'b0, 2'd0);
    for (int k = 0; k < 2; k++) begin
      #1;
      issueCheck($sformatf("rstmid_alloc%0d", k), order[k]);
      exp_q.push_back(rs_mem[order[k]]);
      tick();
    end
    tick();
    auto_free = 1'b0;
    checkOutput("final_sb_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
